// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
//   Shares port A of the 32K x 16 system RAM between two requesters:
//     r0 = CPU data/instruction access
//     r1 = DMA/loader engine
//   At most one access is granted per cycle. The winner's we/addr/wdata are
//   driven onto the RAM port in the grant cycle; read data arrives one cycle
//   later from the synchronous RAM and is flagged by the requester's rvalid.
//
//   Arbitration (default build): fixed priority to r0, with a starvation
//   guard that forces an r1 win once r1 has stalled MAX_WAIT cycles.
//   Arbitration (ARB_ROUND_ROBIN_EN defined): under contention the requester
//   that did not win last time wins; the starvation counter stays at 0.
//
// Ports
//   clk                 system clock, rising edge
//   reset               synchronous reset, active low
//   enable              1 = arbitrate; 0 = no grants, mem_we = 0
//   rN_req/we/addr/wdata  request from requester N (held until rN_gnt)
//   rN_gnt              combinational grant
//   rN_rvalid/rdata     read response, one cycle after a read grant
//   mem_we/addr/din     RAM port A controls (addr/din hold when idle)
//   mem_dout            RAM port A read data (one cycle after address)
// ---------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter int AW       = 15,
  parameter int DW       = 16,
  parameter int MAX_WAIT = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          enable,
  input  logic          r0_req,
  input  logic          r0_we,
  input  logic [AW-1:0] r0_addr,
  input  logic [DW-1:0] r0_wdata,
  output logic          r0_gnt,
  output logic          r0_rvalid,
  output logic [DW-1:0] r0_rdata,
  input  logic          r1_req,
  input  logic          r1_we,
  input  logic [AW-1:0] r1_addr,
  input  logic [DW-1:0] r1_wdata,
  output logic          r1_gnt,
  output logic          r1_rvalid,
  output logic [DW-1:0] r1_rdata,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_din,
  input  logic [DW-1:0] mem_dout
);

  // State records who won in the previous cycle (IDLE = nobody).
  typedef enum logic [1:0] {IDLE, G0, G1} state_t;

  localparam logic [7:0] MAX_WAIT_C = 8'(MAX_WAIT);

  state_t        state_q, state_d;
  logic          last_winner_q, last_winner_d;  // 0 = r0, 1 = r1
  logic          rd_q, rd_d;                    // previous grant was a read
  logic [7:0]    wait_cnt_q, wait_cnt_d;
  logic [AW-1:0] addr_hold_q, addr_hold_d;
  logic [DW-1:0] din_hold_q, din_hold_d;

  logic          arb_on;
  logic          prev_is_r1;
  logic          pick_r1;

  // NOTE: every signal assigned in this block gets a default first so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    arb_on        = reset && enable;
    r0_gnt        = 1'b0;
    r1_gnt        = 1'b0;
    mem_we        = 1'b0;
    mem_addr      = '0;
    mem_din       = '0;
    state_d       = IDLE;
    rd_d          = 1'b0;
    addr_hold_d   = addr_hold_q;
    din_hold_d    = din_hold_q;
    wait_cnt_d    = wait_cnt_q;

    // Most recent winner: last cycle's owner if there was one, otherwise the
    // remembered winner from before the idle gap.
    prev_is_r1    = (state_q == G1) ? 1'b1 :
                    (state_q == G0) ? 1'b0 : last_winner_q;
    last_winner_d = prev_is_r1;

`ifdef ARB_ROUND_ROBIN_EN
    pick_r1    = r1_req && (!r0_req || !prev_is_r1);
    wait_cnt_d = '0;
`else
    // Forced cycle: r1 has waited long enough and overrides r0.
    pick_r1    = r1_req && (!r0_req || (wait_cnt_q >= MAX_WAIT_C));
`endif

    r0_gnt = arb_on && r0_req && !pick_r1;
    r1_gnt = arb_on && pick_r1;

    if (r0_gnt) begin
      mem_we   = r0_we;
      mem_addr = r0_addr;
      mem_din  = r0_wdata;
      state_d  = G0;
      rd_d     = !r0_we;
    end else if (r1_gnt) begin
      mem_we   = r1_we;
      mem_addr = r1_addr;
      mem_din  = r1_wdata;
      state_d  = G1;
      rd_d     = !r1_we;
    end else if (reset) begin
      mem_addr = addr_hold_q;
      mem_din  = din_hold_q;
    end

    if (r0_gnt || r1_gnt) begin
      addr_hold_d = mem_addr;
      din_hold_d  = mem_din;
    end

`ifndef ARB_ROUND_ROBIN_EN
    if (enable) begin
      if (r1_req && !r1_gnt)
        wait_cnt_d = (wait_cnt_q == 8'hFF) ? wait_cnt_q : wait_cnt_q + 8'd1;
      else
        wait_cnt_d = '0;
    end
`endif
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values computed above, independent of statement order.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= IDLE;
      last_winner_q <= 1'b1;
      rd_q          <= 1'b0;
      wait_cnt_q    <= '0;
      addr_hold_q   <= '0;
      din_hold_q    <= '0;
    end else begin
      state_q       <= state_d;
      last_winner_q <= last_winner_d;
      rd_q          <= rd_d;
      wait_cnt_q    <= wait_cnt_d;
      addr_hold_q   <= addr_hold_d;
      din_hold_q    <= din_hold_d;
    end
  end

  // Responses are routed by last cycle's owner. Masking with reset drops a
  // read that was granted just before reset asserts.
  assign r0_rvalid = reset && rd_q && (state_q == G0);
  assign r1_rvalid = reset && rd_q && (state_q == G1);
  assign r0_rdata  = mem_dout;
  assign r1_rdata  = mem_dout;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_port_arbiter
//   Drives mem_port_arbiter with directed and randomized requests against a
//   RAM stand-in. A reference model (grant rules plus a shadow memory) runs on
//   the falling edge, checks grants/RAM controls and queues expected read
//   responses; a separate monitor pops them when responses are due.
// ---------------------------------------------------------------------------
module tb_mem_port_arbiter;

  localparam int AW       = 15;
  localparam int DW       = 16;
  localparam int MAX_WAIT = 8;

  logic          clk;
  logic          reset;
  logic          enable;
  logic          r0_req, r0_we, r0_gnt, r0_rvalid;
  logic [AW-1:0] r0_addr;
  logic [DW-1:0] r0_wdata, r0_rdata;
  logic          r1_req, r1_we, r1_gnt, r1_rvalid;
  logic [AW-1:0] r1_addr;
  logic [DW-1:0] r1_wdata, r1_rdata;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_din;
  logic [DW-1:0] mem_dout;

  mem_port_arbiter #(.AW(AW), .DW(DW), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .r0_req(r0_req), .r0_we(r0_we), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
    .r0_gnt(r0_gnt), .r0_rvalid(r0_rvalid), .r0_rdata(r0_rdata),
    .r1_req(r1_req), .r1_we(r1_we), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
    .r1_gnt(r1_gnt), .r1_rvalid(r1_rvalid), .r1_rdata(r1_rdata),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din),
    .mem_dout(mem_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM stand-in: synchronous write and read on port A.
  logic [DW-1:0] ram       [0:(1<<AW)-1];
  logic [DW-1:0] model_mem [0:(1<<AW)-1];

  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_din;
    mem_dout <= ram[mem_addr];
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  typedef struct {
    bit            who;   // 0 = r0, 1 = r1
    logic [DW-1:0] data;
  } rd_item_t;

  rd_item_t exp_q[$];

  // Reference model state.
  int            m_wait      = 0;
  int            m_last      = 1;
  bit            m_have_last = 0;
  logic [AW-1:0] m_last_addr;
  logic [DW-1:0] m_last_din;

  bit g0_seen = 0, g1_seen = 0;
  bit t4_rec  = 0;
  bit t4_q[$];

  // Model and grant checker.
  always @(negedge clk) begin
    bit            e0, e1, ewe;
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;
    e0 = 0; e1 = 0;
    if (reset && enable) begin
`ifdef ARB_ROUND_ROBIN_EN
      if (r0_req && r1_req) begin
        if (m_last == 1) e0 = 1; else e1 = 1;
      end else begin
        e0 = r0_req; e1 = r1_req;
      end
`else
      if (r1_req && m_wait >= MAX_WAIT) e1 = 1;
      else if (r0_req)                  e0 = 1;
      else if (r1_req)                  e1 = 1;
`endif
    end
    ewe = e0 ? r0_we : (e1 ? r1_we : 1'b0);
    ea  = e0 ? r0_addr  : r1_addr;
    ed  = e0 ? r0_wdata : r1_wdata;

    check("r0_gnt", r0_gnt, e0);
    check("r1_gnt", r1_gnt, e1);
    check("mem_we", mem_we, ewe);
    if (!reset) begin
      check("mem_addr_in_reset", mem_addr, 0);
      check("mem_din_in_reset", mem_din, 0);
    end else if (e0 || e1) begin
      check("mem_addr", mem_addr, ea);
      check("mem_din", mem_din, ed);
    end else if (m_have_last) begin
      check("mem_addr_hold", mem_addr, m_last_addr);
      check("mem_din_hold", mem_din, m_last_din);
    end

    if (!reset) begin
      m_wait = 0; m_last = 1; m_have_last = 0;
    end else begin
      if (enable) m_wait = (r1_req && !e1) ? ((m_wait < 255) ? m_wait + 1 : 255) : 0;
      if (e0 || e1) begin
        m_last      = e1 ? 1 : 0;
        m_have_last = 1;
        m_last_addr = ea;
        m_last_din  = ed;
        if (ewe) model_mem[ea] = ed;
        else     exp_q.push_back('{who: e1, data: model_mem[ea]});
      end
    end

    if (t4_rec) t4_q.push_back(r1_gnt);
    g0_seen = r0_gnt;
    g1_seen = r1_gnt;
  end

  // Response monitor: a queued read must come back in the next cycle.
  always @(posedge clk) begin
    rd_item_t it;
    #2;
    if (exp_q.size() > 0) begin
      it = exp_q.pop_front();
      if (!reset) begin
        check("r0_rvalid_reset_drop", r0_rvalid, 0);
        check("r1_rvalid_reset_drop", r1_rvalid, 0);
      end else begin
        check("r0_rvalid", r0_rvalid, !it.who);
        check("r1_rvalid", r1_rvalid, it.who);
        check(it.who ? "r1_rdata" : "r0_rdata",
              it.who ? r1_rdata : r0_rdata, it.data);
      end
    end else begin
      check("r0_rvalid_idle", r0_rvalid, 0);
      check("r1_rvalid_idle", r1_rvalid, 0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [AW-1:0] rand_addr();
    case ($urandom_range(0, 3))
      0:       return 15'h2005;
      1:       return 15'h0010;
      default: return 15'h0100 + 15'($urandom_range(0, 3));
    endcase
  endfunction

  // Requests are held until granted; a new one may follow a grant at once.
  task automatic rand_cycle();
    if (!r0_req || g0_seen) begin
      r0_req   = ($urandom_range(0, 99) < 60);
      r0_we    = 1'($urandom_range(0, 1));
      r0_addr  = rand_addr();
      r0_wdata = 16'($urandom);
    end
    if (!r1_req || g1_seen) begin
      r1_req   = ($urandom_range(0, 99) < 70);
      r1_we    = ($urandom_range(0, 9) < 3);
      r1_addr  = rand_addr();
      r1_wdata = 16'($urandom);
    end
    enable = ($urandom_range(0, 99) < 90);
    reset  = ($urandom_range(0, 199) != 0);
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) begin
      ram[i]       = 16'(i) ^ 16'h5A5A;
      model_mem[i] = 16'(i) ^ 16'h5A5A;
    end
    ram[15'h2005]       = 16'hBEEF;
    model_mem[15'h2005] = 16'hBEEF;

    // Reset held with both requesters asking.
    reset = 0; enable = 1;
    r0_req = 1; r0_we = 0; r0_addr = 15'h0001; r0_wdata = '0;
    r1_req = 1; r1_we = 0; r1_addr = 15'h0002; r1_wdata = '0;
    repeat (4) tick();
    reset = 1; r0_req = 0; r1_req = 0;
    tick();

    // r1 read alone: data one cycle after grant.
    r1_req = 1; r1_we = 0; r1_addr = 15'h2005;
    tick();
    r1_req = 0;
    tick();

    // r0 write then read of the same word on consecutive cycles.
    r0_req = 1; r0_we = 1; r0_addr = 15'h0010; r0_wdata = 16'h1234;
    tick();
    r0_we = 0;
    tick();
    r0_req = 0;
    tick();

    // Sustained contention from a fresh reset.
    reset = 0;
    tick();
    reset = 1;
    r0_req = 1; r0_we = 0; r0_addr = 15'h0101;
    r1_req = 1; r1_we = 0; r1_addr = 15'h0102;
    t4_rec = 1;
    repeat (27) tick();
    t4_rec = 0;
    r0_req = 0; r1_req = 0;
    tick();
    for (int i = 0; i < t4_q.size(); i++) begin
`ifdef ARB_ROUND_ROBIN_EN
      check("contention_pattern", t4_q[i], (i % 2) == 1);
`else
      check("contention_pattern", t4_q[i], (i % (MAX_WAIT + 1)) == MAX_WAIT);
`endif
    end
    check("contention_len", t4_q.size(), 27);

    // Read granted, then reset: no response; after release r1 wins at once.
    r0_req = 1; r0_we = 0; r0_addr = 15'h2005;
    tick();
    reset = 0; r0_req = 0;
    tick();
    reset = 1;
    r1_req = 1; r1_we = 0; r1_addr = 15'h0010;
    tick();
    r1_req = 0;
    tick();

    // Randomized traffic with occasional enable drops and resets.
    repeat (2000) begin
      rand_cycle();
      tick();
    end

    r0_req = 0; r1_req = 0; enable = 1; reset = 1;
    repeat (3) tick();
    check("responses_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
